if_mem_bus_arbiter: RTL and testbench

- Shares the single Wishbone classic master port between the instruction-fetch requester (IF, read-only) and the data-memory requester (MEM, read/write).
- Sequences one bus transaction at a time.
- Returns response data and errors to the winning requester.
- Generates the if_busy / mem_busy levels that drive the pipeline stall/flush controller's im/mem inputs.

---
 rtl/if_mem_bus_arbiter_pkg.sv | 18 +
 rtl/if_mem_bus_arbiter_timeout.sv | 26 ++
 rtl/if_mem_bus_arbiter.sv | 152 +++++++++++++++
 tb/tb_if_mem_bus_arbiter.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/if_mem_bus_arbiter_pkg.sv
// Shared types for the IF/MEM Wishbone arbiter: FSM states, bus owner, byte-select fill.
package if_mem_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_IF  = 1'b0,
    OWN_MEM = 1'b1
  } owner_t;

  // Instruction fetches are always full-word reads.
  localparam logic DEFAULT_SEL_BIT = 1'b1;

endpackage

// File: rtl/if_mem_bus_arbiter_timeout.sv
// Saturating watchdog counter for one bus transaction; TIMEOUT == 0 disables expiry.
module bus_timeout_counter #(
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam logic [TO_W-1:0] LIMIT = (TIMEOUT == 0) ? '0 : TO_W'(TIMEOUT - 1);

  logic [TO_W-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                     cnt <= '0;
    else if (clear)                cnt <= '0;
    else if (enable && cnt != '1)  cnt <= cnt + 1'b1;
  end

  // Fires in the cycle whose closing edge would bring the count up to TIMEOUT.
  assign expire = (TIMEOUT != 0) && enable && (cnt == LIMIT);

endmodule

// File: rtl/if_mem_bus_arbiter.sv
// Single Wishbone classic master shared by instruction fetch and data memory; MEM has priority.
module if_mem_bus_arbiter
  import if_mem_bus_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 255,
  parameter int TO_W       = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    if_req,
  input  logic [ADDR_WIDTH-1:0]   if_addr,
  input  logic                    if_flush,
  output logic                    if_ack,
  output logic [DATA_WIDTH-1:0]   if_rdata,
  output logic                    if_err,
  output logic                    if_busy,
  input  logic                    mem_req,
  input  logic                    mem_we,
  input  logic [ADDR_WIDTH-1:0]   mem_addr,
  input  logic [DATA_WIDTH-1:0]   mem_wdata,
  input  logic [DATA_WIDTH/8-1:0] mem_sel,
  output logic                    mem_ack,
  output logic [DATA_WIDTH-1:0]   mem_rdata,
  output logic                    mem_err,
  output logic                    mem_busy,
  output logic                    wb_cyc_o,
  output logic                    wb_stb_o,
  output logic                    wb_we_o,
  output logic [ADDR_WIDTH-1:0]   wb_adr_o,
  output logic [DATA_WIDTH-1:0]   wb_dat_o,
  output logic [DATA_WIDTH/8-1:0] wb_sel_o,
  input  logic [DATA_WIDTH-1:0]   wb_dat_i,
  input  logic                    wb_ack_i,
  input  logic                    wb_err_i
);

  localparam int SEL_W = DATA_WIDTH / 8;

  arb_state_t state_q, state_d;
  owner_t     owner_q;
  logic       kill_q;
  logic       grant_mem, grant_if, done, to_en, to_expire;
  logic       kill_hit, bus_err;
  logic [DATA_WIDTH-1:0] bus_data;

  bus_timeout_counter #(.TIMEOUT(TIMEOUT), .TO_W(TO_W)) u_timeout (
    .clk    (clk),
    .reset  (reset),
    .clear  (grant_mem | grant_if),
    .enable (to_en),
    .expire (to_expire)
  );

  always_comb begin
    state_d   = state_q;
    grant_mem = 1'b0;
    grant_if  = 1'b0;
    done      = 1'b0;
    to_en     = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_req) begin
          grant_mem = 1'b1;
          state_d   = BUS;
        end else if (if_req && !if_flush) begin
          grant_if = 1'b1;
          state_d  = BUS;
        end
      end
      BUS: begin
        to_en = 1'b1;
        if (wb_ack_i || wb_err_i || to_expire) begin
          done    = 1'b1;
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Completion without an ack can only be a timeout, so it reports as an error too.
  assign bus_err  = wb_err_i | ~wb_ack_i;
  assign bus_data = (wb_ack_i && !wb_err_i) ? wb_dat_i : '0;
  assign kill_hit = (state_q == BUS) && (owner_q == OWN_IF) && if_flush;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner_q   <= OWN_IF;
      kill_q    <= 1'b0;
      wb_cyc_o  <= 1'b0;
      wb_stb_o  <= 1'b0;
      wb_we_o   <= 1'b0;
      wb_adr_o  <= '0;
      wb_dat_o  <= '0;
      wb_sel_o  <= '0;
      if_ack    <= 1'b0;
      if_err    <= 1'b0;
      if_rdata  <= '0;
      mem_ack   <= 1'b0;
      mem_err   <= 1'b0;
      mem_rdata <= '0;
    end else begin
      if_ack  <= 1'b0;
      mem_ack <= 1'b0;
      if (grant_mem) begin
        owner_q  <= OWN_MEM;
        wb_we_o  <= mem_we;
        wb_adr_o <= mem_addr;
        wb_dat_o <= mem_wdata;
        wb_sel_o <= mem_sel;
        wb_cyc_o <= 1'b1;
        wb_stb_o <= 1'b1;
      end else if (grant_if) begin
        owner_q  <= OWN_IF;
        wb_we_o  <= 1'b0;
        wb_adr_o <= if_addr;
        wb_dat_o <= '0;
        wb_sel_o <= {SEL_W{DEFAULT_SEL_BIT}};
        wb_cyc_o <= 1'b1;
        wb_stb_o <= 1'b1;
      end
      if (kill_hit) kill_q <= 1'b1;
      if (done) begin
        wb_cyc_o <= 1'b0;
        wb_stb_o <= 1'b0;
        if (owner_q == OWN_MEM) begin
          mem_ack   <= 1'b1;
          mem_err   <= bus_err;
          mem_rdata <= bus_data;
        end else begin
          // A flush landing in the completion cycle must still suppress the ack.
          if_ack   <= ~(kill_q | kill_hit);
          if_err   <= bus_err;
          if_rdata <= bus_data;
        end
      end
      if (state_q == RESP) kill_q <= 1'b0;
    end
  end

  assign if_busy  = if_req & ~if_flush & ~if_ack;
  assign mem_busy = mem_req & ~mem_ack;

endmodule

// File: tb/tb_if_mem_bus_arbiter.sv
// Scoreboard bench for if_mem_bus_arbiter with a behavioural Wishbone slave (waits/err/no-ack).
module tb_if_mem_bus_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          if_req, if_flush, if_ack, if_err, if_busy;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          mem_req, mem_we, mem_ack, mem_err, mem_busy;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic [3:0]    mem_sel;
  logic          wb_cyc_o, wb_stb_o, wb_we_o, wb_ack_i, wb_err_i;
  logic [AW-1:0] wb_adr_o;
  logic [DW-1:0] wb_dat_o, wb_dat_i;
  logic [3:0]    wb_sel_o;

  logic [7:0] wcnt, waits;
  logic       err_mode, no_ack;

  typedef struct {
    logic          is_mem;
    logic [DW-1:0] rdata;
    logic          err;
  } exp_t;
  exp_t sb[$];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  if_mem_bus_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(4), .TO_W(8)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush), .if_ack(if_ack),
    .if_rdata(if_rdata), .if_err(if_err), .if_busy(if_busy),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_sel(mem_sel), .mem_ack(mem_ack), .mem_rdata(mem_rdata), .mem_err(mem_err),
    .mem_busy(mem_busy),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o), .wb_adr_o(wb_adr_o),
    .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o), .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i),
    .wb_err_i(wb_err_i)
  );

  function automatic logic [DW-1:0] slave_word(input logic [AW-1:0] a);
    return a ^ 32'hA5A5_1234;
  endfunction

  // Slave: responds once the strobe has been held for 'waits' extra cycles.
  always_ff @(posedge clk) begin
    if (!wb_cyc_o || wb_ack_i || wb_err_i) wcnt <= '0;
    else                                   wcnt <= wcnt + 8'd1;
  end
  assign wb_dat_i = slave_word(wb_adr_o);
  assign wb_ack_i = wb_cyc_o & wb_stb_o & ~no_ack & ~err_mode & (wcnt == waits);
  assign wb_err_i = wb_cyc_o & wb_stb_o & ~no_ack &  err_mode & (wcnt == waits);

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic is_mem, input logic [DW-1:0] d, input logic e);
    exp_t x;
    x.is_mem = is_mem;
    x.rdata  = d;
    x.err    = e;
    sb.push_back(x);
  endtask

  // Response monitor: every ack must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!reset && (if_ack || mem_ack)) begin
      if (sb.size() == 0) begin
        chk("unexpected_ack", {30'd0, mem_ack, if_ack}, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("ack_owner", {31'd0, mem_ack}, {31'd0, e.is_mem});
        chk("resp_data", mem_ack ? mem_rdata : if_rdata, e.rdata);
        chk("resp_err", {31'd0, mem_ack ? mem_err : if_err}, {31'd0, e.err});
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    reset = 1'b1; if_req = 0; if_addr = '0; if_flush = 0;
    mem_req = 0; mem_we = 0; mem_addr = '0; mem_wdata = '0; mem_sel = '0;
    waits = 0; err_mode = 0; no_ack = 0;
    #23;
    chk("rst_cyc", {31'd0, wb_cyc_o}, 0);
    chk("rst_stb", {31'd0, wb_stb_o}, 0);
    chk("rst_we", {31'd0, wb_we_o}, 0);
    chk("rst_adr", wb_adr_o, 0);
    chk("rst_acks", {30'd0, if_ack, mem_ack}, 0);
    @(negedge clk) reset = 1'b0;
    tick();

    // IF-only read, zero-wait slave
    if_req = 1; if_addr = 32'h8000_0000;
    push(0, slave_word(32'h8000_0000), 0);
    #1 chk("t1_busy_c0", {31'd0, if_busy}, 1);
    tick();
    chk("t1_cyc_c1", {31'd0, wb_cyc_o & wb_stb_o}, 1);
    chk("t1_adr", wb_adr_o, 32'h8000_0000);
    chk("t1_sel", {28'd0, wb_sel_o}, 32'hF);
    tick();
    chk("t1_ack_c2", {31'd0, if_ack}, 1);
    chk("t1_busy_c2", {31'd0, if_busy}, 0);
    if_req = 0;
    tick();

    // Simultaneous requests: MEM write first, IF grant two cycles after MEM ack
    if_req = 1; if_addr = 32'h0000_0100;
    mem_req = 1; mem_we = 1; mem_addr = 32'h8040_0000; mem_wdata = 32'hDEAD_BEEF; mem_sel = 4'hF;
    push(1, slave_word(32'h8040_0000), 0);
    push(0, slave_word(32'h0000_0100), 0);
    tick();
    chk("t2_we", {31'd0, wb_we_o}, 1);
    chk("t2_adr", wb_adr_o, 32'h8040_0000);
    chk("t2_dat", wb_dat_o, 32'hDEAD_BEEF);
    tick();
    chk("t2_mem_ack", {31'd0, mem_ack}, 1);
    mem_req = 0; mem_we = 0;
    tick();
    chk("t2_turnaround", {31'd0, wb_cyc_o}, 0);
    tick();
    chk("t2_if_cyc", {31'd0, wb_cyc_o}, 1);
    chk("t2_if_we", {31'd0, wb_we_o}, 0);
    chk("t2_if_adr", wb_adr_o, 32'h0000_0100);
    tick();
    chk("t2_if_ack", {31'd0, if_ack}, 1);
    if_req = 0;
    tick();

    // Flush during an IF bus cycle with a 3-wait slave
    waits = 3; if_req = 1; if_addr = 32'h0000_0200;
    tick();
    chk("t3_cyc", {31'd0, wb_cyc_o}, 1);
    tick();
    if_flush = 1;
    #1 chk("t3_busy_flush", {31'd0, if_busy}, 0);
    tick();
    if_flush = 0; if_req = 0;
    tick();
    chk("t3_cyc_held", {31'd0, wb_cyc_o}, 1);
    tick();
    chk("t3_no_ack", {31'd0, if_ack}, 0);
    chk("t3_cyc_drop", {31'd0, wb_cyc_o}, 0);
    tick();
    chk("t3_idle", {31'd0, wb_cyc_o}, 0);
    waits = 0;

    // Slave error on a MEM read
    err_mode = 1; mem_req = 1; mem_addr = 32'h0000_0300; mem_sel = 4'h3;
    push(1, 32'd0, 1);
    tick();
    chk("t4_sel", {28'd0, wb_sel_o}, 32'h3);
    tick();
    chk("t4_ack", {31'd0, mem_ack}, 1);
    mem_req = 0;
    tick();
    err_mode = 0;

    // Timeout with TIMEOUT=4, then a normal IF fetch
    no_ack = 1; mem_req = 1; mem_addr = 32'h0000_0400;
    push(1, 32'd0, 1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t5_cyc_held", {31'd0, wb_cyc_o}, 1);
    end
    tick();
    chk("t5_cyc_drop", {31'd0, wb_cyc_o}, 0);
    chk("t5_ack", {31'd0, mem_ack}, 1);
    mem_req = 0; no_ack = 0;
    tick();
    if_req = 1; if_addr = 32'h0000_0480;
    push(0, slave_word(32'h0000_0480), 0);
    tick();
    tick();
    chk("t5_if_ack", {31'd0, if_ack}, 1);
    if_req = 0;
    tick();

    // Asynchronous reset mid-BUS
    waits = 3; if_req = 1; if_addr = 32'h0000_0500;
    tick();
    chk("t6_cyc", {31'd0, wb_cyc_o}, 1);
    #2 reset = 1;
    #1 chk("t6_async_cyc", {31'd0, wb_cyc_o | wb_stb_o}, 0);
    if_req = 0;
    @(negedge clk) reset = 0;
    waits = 0;
    tick();
    chk("t6_post_cyc", {31'd0, wb_cyc_o}, 0);
    chk("t6_no_ack", {30'd0, if_ack, mem_ack}, 0);
    mem_req = 1; mem_addr = 32'h0000_0600; mem_sel = 4'hF;
    push(1, slave_word(32'h0000_0600), 0);
    tick();
    chk("t6_new_cyc", {31'd0, wb_cyc_o}, 1);
    tick();
    chk("t6_new_ack", {31'd0, mem_ack}, 1);
    mem_req = 0;
    tick();
    tick();
    chk("sb_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
